mem_port_arbiter: RTL and testbench

- Shares the single memory port (mem_read/mem_write/mem_byte_enable/mem_address/mem_wdata/mem_rdata/mem_resp) between an instruction-fetch requester (I-side) and a load/store requester (D-side).
- Both sides use the CPU's existing level-request / single-cycle-resp handshake.
- Sits between the CPU core and the memory/cache. Grants one transaction at a time, latches its command into registers, routes the response back to the granted requester, and flags memory hangs.

---
 rtl/mem_port_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single memory port: instruction fetch (I) and load/store (D).
// One transaction at a time, registered command, combinational response routing, sticky watchdog.
module mem_port_arbiter #(
  parameter int ROUND_ROBIN    = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_read,
  input  logic [31:0] i_address,
  output logic [31:0] i_rdata,
  output logic        i_resp,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [3:0]  d_byte_enable,
  input  logic [31:0] d_address,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_resp,
  output logic        mem_read,
  output logic        mem_write,
  output logic [3:0]  mem_byte_enable,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp,
  output logic        busy,
  output logic        timeout_err
);

  localparam bit WD_EN = (TIMEOUT_CYCLES > 0);
  localparam int CW    = WD_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t        state;
  logic          last_grant_d;
  logic [CW-1:0] wd_cnt;
  logic          i_pend;
  logic          d_pend;
  logic          grant_i;
  logic          grant_d;
  logic          serving;

  assign serving = (state != IDLE);

  always_comb begin
    i_pend  = i_read;
    d_pend  = d_read | d_write;
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state == IDLE) begin
      if (i_pend && d_pend) begin
        // Round robin hands the contended slot to whoever did not win last time.
        if (ROUND_ROBIN != 0) begin
          grant_d = ~last_grant_d;
          grant_i = last_grant_d;
        end else begin
          grant_d = 1'b1;
        end
      end else if (i_pend) begin
        grant_i = 1'b1;
      end else if (d_pend) begin
        grant_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      last_grant_d    <= 1'b0;
      mem_read        <= 1'b0;
      mem_write       <= 1'b0;
      mem_byte_enable <= 4'b0000;
      mem_address     <= 32'd0;
      mem_wdata       <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_i) begin
            state           <= SERVE_I;
            mem_read        <= 1'b1;
            mem_write       <= 1'b0;
            mem_byte_enable <= 4'b1111;
            mem_address     <= i_address;
            mem_wdata       <= 32'd0;
            last_grant_d    <= 1'b0;
          end else if (grant_d) begin
            // A simultaneous read+write request is served as a write.
            state           <= SERVE_D;
            mem_read        <= d_read & ~d_write;
            mem_write       <= d_write;
            mem_byte_enable <= d_byte_enable;
            mem_address     <= d_address;
            mem_wdata       <= d_wdata;
            last_grant_d    <= 1'b1;
          end
        end
        SERVE_I, SERVE_D: begin
          if (mem_resp) begin
            state     <= IDLE;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
        end
      endcase
    end
  end

  // Watchdog: counts stalled serve cycles, saturates, and latches the error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else if (!serving || mem_resp) begin
      wd_cnt <= '0;
    end else if (WD_EN && (wd_cnt != TO_MAX)) begin
      wd_cnt <= wd_cnt + CW'(1);
      if (wd_cnt == TO_MAX - CW'(1)) begin
        timeout_err <= 1'b1;
      end
    end
  end

  assign i_resp  = (state == SERVE_I) & mem_resp;
  assign d_resp  = (state == SERVE_D) & mem_resp;
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;
  assign busy    = serving;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table for single transactions plus
// hand sequences for contention, watchdog and asynchronous reset.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_read;
  logic [31:0] i_address;
  logic        d_read;
  logic        d_write;
  logic [3:0]  d_byte_enable;
  logic [31:0] d_address;
  logic [31:0] d_wdata;
  logic [31:0] mem_rdata;
  logic        mem_resp;

  // Instance a: round robin, 8-cycle watchdog. Instance b: D priority, watchdog off.
  logic [31:0] i_rdata_a, d_rdata_a, mem_address_a, mem_wdata_a;
  logic        i_resp_a, d_resp_a, mem_read_a, mem_write_a, busy_a, timeout_err_a;
  logic [3:0]  mem_byte_enable_a;
  logic [31:0] i_rdata_b, d_rdata_b, mem_address_b, mem_wdata_b;
  logic        i_resp_b, d_resp_b, mem_read_b, mem_write_b, busy_b, timeout_err_b;
  logic [3:0]  mem_byte_enable_b;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ROUND_ROBIN(1), .TIMEOUT_CYCLES(8)) dut_a (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata_a), .i_resp(i_resp_a),
    .d_read(d_read), .d_write(d_write), .d_byte_enable(d_byte_enable),
    .d_address(d_address), .d_wdata(d_wdata), .d_rdata(d_rdata_a), .d_resp(d_resp_a),
    .mem_read(mem_read_a), .mem_write(mem_write_a), .mem_byte_enable(mem_byte_enable_a),
    .mem_address(mem_address_a), .mem_wdata(mem_wdata_a),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .busy(busy_a), .timeout_err(timeout_err_a)
  );

  mem_port_arbiter #(.ROUND_ROBIN(0), .TIMEOUT_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata_b), .i_resp(i_resp_b),
    .d_read(d_read), .d_write(d_write), .d_byte_enable(d_byte_enable),
    .d_address(d_address), .d_wdata(d_wdata), .d_rdata(d_rdata_b), .d_resp(d_resp_b),
    .mem_read(mem_read_b), .mem_write(mem_write_b), .mem_byte_enable(mem_byte_enable_b),
    .mem_address(mem_address_b), .mem_wdata(mem_wdata_b),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .busy(busy_b), .timeout_err(timeout_err_b)
  );

  typedef struct {
    logic        i_read;
    logic [31:0] i_address;
    logic        d_read;
    logic        d_write;
    logic [3:0]  d_be;
    logic [31:0] d_address;
    logic [31:0] d_wdata;
    logic        mem_resp;
    logic [31:0] mem_rdata;
    logic        e_rd;
    logic        e_wr;
    logic [3:0]  e_be;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_iresp;
    logic        e_dresp;
    logic        e_busy;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  function automatic vec_t mk(
    input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
    input logic [3:0] be, input logic [31:0] da, input logic [31:0] dwd,
    input logic mr, input logic [31:0] mrd,
    input logic erd, input logic ewr, input logic [3:0] ebe, input logic [31:0] ea,
    input logic [31:0] ewd, input logic eir, input logic edr, input logic eb);
    vec_t v;
    v.i_read = ir; v.i_address = ia; v.d_read = dr; v.d_write = dw; v.d_be = be;
    v.d_address = da; v.d_wdata = dwd; v.mem_resp = mr; v.mem_rdata = mrd;
    v.e_rd = erd; v.e_wr = ewr; v.e_be = ebe; v.e_addr = ea; v.e_wdata = ewd;
    v.e_iresp = eir; v.e_dresp = edr; v.e_busy = eb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_read = 1'b0; i_address = 32'd0; d_read = 1'b0; d_write = 1'b0;
    d_byte_enable = 4'd0; d_address = 32'd0; d_wdata = 32'd0;
    mem_rdata = 32'd0; mem_resp = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b0;
    #1;
    chk("reset_outputs_a",
        {mem_read_a, mem_write_a, mem_byte_enable_a, mem_address_a, mem_wdata_a,
         i_resp_a, d_resp_a, busy_a, timeout_err_a}, '0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    vec_t v;
    // I fetch, D write, spurious response, read+write collision with mid-serve address change, D read.
    vecs[0]  = mk(1, 32'h60, 0, 0, 4'h0, 0, 0, 0, 0,             0, 0, 4'h0, 32'h0,   32'h0,        0, 0, 0);
    vecs[1]  = mk(1, 32'h60, 0, 0, 4'h0, 0, 0, 0, 0,             1, 0, 4'hF, 32'h60,  32'h0,        0, 0, 1);
    vecs[2]  = mk(1, 32'h60, 0, 0, 4'h0, 0, 0, 0, 0,             1, 0, 4'hF, 32'h60,  32'h0,        0, 0, 1);
    vecs[3]  = mk(1, 32'h60, 0, 0, 4'h0, 0, 0, 1, 32'hDEADBEEF,  1, 0, 4'hF, 32'h60,  32'h0,        1, 0, 1);
    vecs[4]  = mk(0, 0,      0, 0, 4'h0, 0, 0, 0, 0,             0, 0, 4'hF, 32'h60,  32'h0,        0, 0, 0);
    vecs[5]  = mk(0, 0, 0, 1, 4'h3, 32'h100, 32'h12345678, 0, 0, 0, 0, 4'hF, 32'h60,  32'h0,        0, 0, 0);
    vecs[6]  = mk(0, 0, 0, 1, 4'h3, 32'h100, 32'h12345678, 0, 0, 0, 1, 4'h3, 32'h100, 32'h12345678, 0, 0, 1);
    vecs[7]  = mk(0, 0, 0, 1, 4'h3, 32'h100, 32'h12345678, 1, 32'h0BADF00D,
                                                                 0, 1, 4'h3, 32'h100, 32'h12345678, 0, 1, 1);
    vecs[8]  = mk(0, 0,      0, 0, 4'h0, 0, 0, 0, 0,             0, 0, 4'h3, 32'h100, 32'h12345678, 0, 0, 0);
    vecs[9]  = mk(0, 0,      0, 0, 4'h0, 0, 0, 1, 32'hAA,        0, 0, 4'h3, 32'h100, 32'h12345678, 0, 0, 0);
    vecs[10] = mk(0, 0, 1, 1, 4'hF, 32'h104, 32'hA5A5A5A5, 0, 0, 0, 0, 4'h3, 32'h100, 32'h12345678, 0, 0, 0);
    vecs[11] = mk(0, 0, 1, 1, 4'hF, 32'h104, 32'hA5A5A5A5, 0, 0, 0, 1, 4'hF, 32'h104, 32'hA5A5A5A5, 0, 0, 1);
    vecs[12] = mk(0, 0, 1, 1, 4'hF, 32'h200, 32'hA5A5A5A5, 0, 0, 0, 1, 4'hF, 32'h104, 32'hA5A5A5A5, 0, 0, 1);
    vecs[13] = mk(0, 0, 1, 1, 4'hF, 32'h200, 32'hA5A5A5A5, 1, 32'h11, 0, 1, 4'hF, 32'h104, 32'hA5A5A5A5, 0, 1, 1);
    vecs[14] = mk(0, 0,      0, 0, 4'h0, 0, 0, 0, 0,             0, 0, 4'hF, 32'h104, 32'hA5A5A5A5, 0, 0, 0);
    vecs[15] = mk(0, 0, 1, 0, 4'h0, 32'h300, 32'h55, 0, 0,       0, 0, 4'hF, 32'h104, 32'hA5A5A5A5, 0, 0, 0);
    vecs[16] = mk(0, 0, 1, 0, 4'h0, 32'h300, 32'h55, 0, 0,       1, 0, 4'h0, 32'h300, 32'h55,       0, 0, 1);
    vecs[17] = mk(0, 0, 1, 0, 4'h0, 32'h300, 32'h55, 1, 32'hCAFEF00D,
                                                                 1, 0, 4'h0, 32'h300, 32'h55,       0, 1, 1);
    vecs[18] = mk(0, 0,      0, 0, 4'h0, 0, 0, 0, 0,             0, 0, 4'h0, 32'h300, 32'h55,       0, 0, 0);

    do_reset();
    for (int k = 0; k < NV; k++) begin
      v = vecs[k];
      i_read = v.i_read; i_address = v.i_address; d_read = v.d_read; d_write = v.d_write;
      d_byte_enable = v.d_be; d_address = v.d_address; d_wdata = v.d_wdata;
      mem_resp = v.mem_resp; mem_rdata = v.mem_rdata;
      #1;
      chk($sformatf("vec%0d", k),
          {mem_read_a, mem_write_a, mem_byte_enable_a, mem_address_a, mem_wdata_a,
           i_resp_a, d_resp_a, busy_a},
          {v.e_rd, v.e_wr, v.e_be, v.e_addr, v.e_wdata, v.e_iresp, v.e_dresp, v.e_busy});
      if (v.e_iresp) chk($sformatf("vec%0d_i_rdata", k), i_rdata_a, v.mem_rdata);
      if (v.e_dresp) chk($sformatf("vec%0d_d_rdata", k), d_rdata_a, v.mem_rdata);
      step();
    end

    // Contention with both sides held: a alternates D,I,D,I; b always picks D.
    do_reset();
    i_read = 1'b1; i_address = 32'h1000;
    d_read = 1'b1; d_address = 32'h2000; d_byte_enable = 4'h6; d_wdata = 32'h77;
    for (int g = 0; g < 4; g++) begin
      logic exp_d;
      exp_d = (g % 2 == 0);
      chk($sformatf("rr%0d_bubble", g), {busy_a, busy_b}, 2'b00);
      step();
      chk($sformatf("rr%0d_grant_a", g), {busy_a, mem_read_a, mem_address_a},
          {1'b1, 1'b1, exp_d ? 32'h2000 : 32'h1000});
      chk($sformatf("rr%0d_grant_b", g),
          {busy_b, mem_read_b, mem_write_b, mem_byte_enable_b, mem_address_b, mem_wdata_b},
          {1'b1, 1'b1, 1'b0, 4'h6, 32'h2000, 32'h77});
      step();
      mem_resp = 1'b1; mem_rdata = 32'h100 + 32'(g);
      #1;
      chk($sformatf("rr%0d_resp_a", g), {i_resp_a, d_resp_a}, {~exp_d, exp_d});
      chk($sformatf("rr%0d_resp_b", g), {i_resp_b, d_resp_b, d_rdata_b, i_rdata_b},
          {1'b0, 1'b1, 32'h100 + 32'(g), 32'h100 + 32'(g)});
      step();
      mem_resp = 1'b0;
    end
    chk("rr_final_bubble", {busy_a, busy_b}, 2'b00);

    // Watchdog: err appears after exactly eight stalled serve cycles and sticks.
    do_reset();
    i_read = 1'b1; i_address = 32'h40;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk($sformatf("wd_cycle%0d", k), {busy_a, timeout_err_a}, 2'b10);
    end
    step();
    chk("wd_set", {busy_a, timeout_err_a, timeout_err_b}, 3'b110);
    repeat (3) step();
    chk("wd_sticky", {busy_a, mem_read_a, timeout_err_a}, 3'b111);
    mem_resp = 1'b1; mem_rdata = 32'h5A5A0001;
    #1;
    chk("wd_late_resp", {i_resp_a, d_resp_a, i_rdata_a}, {1'b1, 1'b0, 32'h5A5A0001});
    step();
    mem_resp = 1'b0; i_read = 1'b0;
    chk("wd_after_done", {busy_a, mem_read_a, timeout_err_a, timeout_err_b}, 4'b0010);

    // Asynchronous reset dropped between edges while a response is in flight.
    i_read = 1'b1; i_address = 32'h80;
    step();
    step();
    #1;
    mem_resp = 1'b1;
    #1;
    chk("arst_pre", {i_resp_a, busy_a, mem_read_a}, 3'b111);
    rst = 1'b0;
    #1;
    chk("arst_now", {mem_read_a, mem_write_a, busy_a, i_resp_a, d_resp_a, timeout_err_a,
                     mem_address_a, busy_b, i_resp_b}, '0);
    #1;
    i_read = 1'b0; mem_resp = 1'b0;
    rst = 1'b1;
    step();
    chk("arst_release_idle", {busy_a, mem_read_a, busy_b, mem_read_b}, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
